// File: rtl/apb_i2c_master_arb.sv
// Purpose: two-requester round-robin arbiter in front of a single APB master port.
// Latency: accept -> SETUP (1) -> ACCESS (>=1) -> response pulse; accept-to-accept is at least 4 cycles.
// Backpressure: requesters hold REQ_VALID until REQ_ACCEPT; the APB slave stalls with PREADY, bounded by WAIT_LIMIT.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   REQ_VALID/WRITE[1:0]     per-requester request and direction
//   REQ_ADDR/WDATA[63:0]     packed per-requester address / write data ([31:0] = requester 0)
//   REQ_ACCEPT[1:0]          one-cycle pulse when a request is latched
//   RSP_VALID[1:0]           one-cycle completion pulse to the owner
//   RSP_RDATA/ERR/TIMEOUT    completion result, held until the next completion
//   BUSY                     transfer in progress
//   PSELx..PWDATA            APB master outputs
//   PRDATA/PREADY/PSLVERR    APB slave inputs
module apb_i2c_master_arb #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WRITE,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  output logic [1:0]  REQ_ACCEPT,
  output logic [1:0]  RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        RSP_TIMEOUT,
  output logic        BUSY,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  // A zero WAIT_LIMIT still needs a legal one-bit counter; it just never fires.
  localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          grant_ok;
  logic          grant_id;
  logic          timeout_hit;

  // Reset release is retimed through two flops so the first grant lands
  // well clear of the deassertion edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  // No grant in the IDLE cycle that carries the response pulse: this is the
  // mandatory idle gap that makes back-to-back transfers 4 cycles apart.
  assign grant_ok = rst_sync[1] && !(|RSP_VALID);

  // Both valid: take the one not served last. One valid: take it outright.
  assign grant_id = (&REQ_VALID) ? ~last_grant : REQ_VALID[1];

  assign wait_nxt    = wait_cnt + CW'(1);
  assign timeout_hit = (WAIT_LIMIT != 0) && (wait_nxt == CW'(WAIT_LIMIT));

  assign BUSY = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      REQ_ACCEPT  <= '0;
      RSP_VALID   <= '0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      wait_cnt    <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;  // so requester 0 wins the first contested grant
    end else begin
      REQ_ACCEPT <= '0;
      RSP_VALID  <= '0;
      case (state)
        IDLE: begin
          if (grant_ok && (|REQ_VALID)) begin
            state      <= SETUP;
            owner      <= grant_id;
            last_grant <= grant_id;
            REQ_ACCEPT <= grant_id ? 2'b10 : 2'b01;
            PWRITE     <= REQ_WRITE[grant_id];
            PADDR      <= grant_id ? REQ_ADDR[63:32]  : REQ_ADDR[31:0];
            PWDATA     <= grant_id ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
            PSELx      <= 1'b1;
            wait_cnt   <= '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          // PREADY is tested first so a ready on the last allowed cycle wins.
          if (PREADY) begin
            state       <= IDLE;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            RSP_VALID   <= owner ? 2'b10 : 2'b01;
            RSP_RDATA   <= PWRITE ? 32'h0 : PRDATA;
            RSP_ERR     <= PSLVERR;
            RSP_TIMEOUT <= 1'b0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            RSP_VALID   <= owner ? 2'b10 : 2'b01;
            RSP_RDATA   <= 32'h0;
            RSP_ERR     <= 1'b1;
            RSP_TIMEOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_i2c_master_arb.sv
// Purpose: bench for apb_i2c_master_arb: directed scenarios plus randomized traffic against a transfer-level model.
// Latency: model predicts every output on every cycle; directed checks pin key values with literals.
// Backpressure: PREADY is driven randomly, including long stalls that reach the wait limit.
module tb_apb_i2c_master_arb;

  localparam int WAIT_LIMIT = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic [1:0]  REQ_VALID = '0;
  logic [1:0]  REQ_WRITE = '0;
  logic [63:0] REQ_ADDR = '0;
  logic [63:0] REQ_WDATA = '0;
  logic [1:0]  REQ_ACCEPT;
  logic [1:0]  RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        BUSY;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  apb_i2c_master_arb #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_ACCEPT(REQ_ACCEPT), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial forever #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- transfer-level model ----------------
  // m_age: 0 = setup cycle, k>=1 = k-th access cycle of the current transfer.
  int          m_sync = 0;
  int          m_age = 0;
  int          m_g = 0;
  bit          m_active = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  bit          m_cool = 1'b0;
  bit          m_done = 1'b0;
  logic [1:0]  e_accept = '0;
  logic [1:0]  e_rsp = '0;
  logic [31:0] e_rdata = '0;
  logic [31:0] e_paddr = '0;
  logic [31:0] e_pwdata = '0;
  logic        e_err = 1'b0;
  logic        e_to = 1'b0;
  logic        e_pwrite = 1'b0;

  initial forever begin
    @(posedge PCLK or negedge PRESETn);
    if (!PRESETn) begin
      m_sync = 0; m_age = 0; m_active = 1'b0; m_owner = 1'b0;
      m_last = 1'b1; m_cool = 1'b0;
      e_accept = '0; e_rsp = '0; e_rdata = '0; e_paddr = '0; e_pwdata = '0;
      e_err = 1'b0; e_to = 1'b0; e_pwrite = 1'b0;
    end else begin
      m_done = 1'b0;
      e_accept = '0;
      e_rsp = '0;
      if (m_active) begin
        if (m_age == 0) begin
          m_age = 1;
        end else if (PREADY) begin
          m_done = 1'b1;
          e_rdata = e_pwrite ? 32'h0 : PRDATA;
          e_err = PSLVERR;
          e_to = 1'b0;
        end else if (WAIT_LIMIT != 0 && m_age == WAIT_LIMIT) begin
          m_done = 1'b1;
          e_rdata = 32'h0;
          e_err = 1'b1;
          e_to = 1'b1;
        end else begin
          m_age = m_age + 1;
        end
        if (m_done) begin
          e_rsp[m_owner] = 1'b1;
          m_active = 1'b0;
        end
      end else if (m_sync >= 2 && !m_cool && REQ_VALID != 2'b00) begin
        if (REQ_VALID == 2'b11) m_g = m_last ? 0 : 1;
        else m_g = REQ_VALID[1] ? 1 : 0;
        m_active = 1'b1;
        m_age = 0;
        m_owner = m_g[0];
        m_last = m_g[0];
        e_accept = (m_g == 1) ? 2'b10 : 2'b01;
        e_pwrite = REQ_WRITE[m_g];
        e_paddr = REQ_ADDR[m_g*32 +: 32];
        e_pwdata = REQ_WDATA[m_g*32 +: 32];
      end
      m_cool = m_done;
      if (m_sync < 2) m_sync = m_sync + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge PCLK);
    if (chk_en) begin
      chk("accept",      REQ_ACCEPT,  e_accept);
      chk("rsp_valid",   RSP_VALID,   e_rsp);
      chk("rsp_rdata",   RSP_RDATA,   e_rdata);
      chk("rsp_err",     RSP_ERR,     e_err);
      chk("rsp_timeout", RSP_TIMEOUT, e_to);
      chk("busy",        BUSY,        m_active);
      chk("psel",        PSELx,       m_active);
      chk("penable",     PENABLE,     m_active && (m_age >= 1));
      chk("pwrite",      PWRITE,      e_pwrite);
      chk("paddr",       PADDR,       e_paddr);
      chk("pwdata",      PWDATA,      e_pwdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    REQ_WRITE[i] = wr;
    REQ_ADDR[i*32 +: 32] = a;
    REQ_WDATA[i*32 +: 32] = d;
    REQ_VALID[i] = 1'b1;
  endtask

  task automatic wait_acc(output logic [1:0] got, output int n);
    got = 2'b00;
    n = 0;
    while (n < 40 && got == 2'b00) begin
      step();
      n++;
      got = REQ_ACCEPT;
    end
    total++;
    if (got == 2'b00) begin
      bad++;
      $display("FAIL accept_wait: REQ_ACCEPT stayed 00 for 40 cycles, required a grant");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required the run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] got;
    logic [1:0] rr_exp [4];
    int n;
    int mode;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    mode = 1;

    #1 PRESETn = 1'b0;
    #2 chk_en = 1'b1;
    step(); step();
    chk("rst_psel", PSELx, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_accept", REQ_ACCEPT, 2'b00);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_rdata", RSP_RDATA, 32'h0);

    // Req0 write, PREADY tied high; request already pending across reset release.
    set_req(0, 1'b1, 32'h8, 32'h1A5);
    PREADY = 1'b1;
    PRDATA = 32'h12345678;
    PRESETn = 1'b1;
    step();
    chk("sync_edge1_accept", REQ_ACCEPT, 2'b00);
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    chk("d1_grant", got, 2'b01);
    chk("d1_setup_psel", PSELx, 1'b1);
    chk("d1_setup_penable", PENABLE, 1'b0);
    chk("d1_paddr", PADDR, 32'h8);
    chk("d1_pwdata", PWDATA, 32'h1A5);
    step();
    chk("d1_access_penable", PENABLE, 1'b1);
    chk("d1_access_paddr", PADDR, 32'h8);
    step();
    chk("d1_rsp_valid", RSP_VALID, 2'b01);
    chk("d1_rsp_err", RSP_ERR, 1'b0);
    chk("d1_rsp_rdata", RSP_RDATA, 32'h0);
    chk("d1_psel_low", PSELx, 1'b0);
    step(); step();

    // Req1 read with three stalled ACCESS cycles.
    PREADY = 1'b0;
    set_req(1, 1'b0, 32'h4, 32'h0);
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    chk("d2_grant", got, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("d2_paddr_stable", PADDR, 32'h4);
      chk("d2_penable", PENABLE, 1'b1);
    end
    PREADY = 1'b1;
    PRDATA = 32'hDEADBEEF;
    step();
    chk("d2_rsp_valid", RSP_VALID, 2'b10);
    chk("d2_rsp_rdata", RSP_RDATA, 32'hDEADBEEF);
    step(); step();

    // Both requesters continuously valid: strict alternation, 4-cycle spacing.
    set_req(0, 1'b1, 32'h100, 32'hA0A0A0A0);
    set_req(1, 1'b1, 32'h200, 32'hB0B0B0B0);
    for (int k = 0; k < 4; k++) begin
      wait_acc(got, n);
      chk("rr_grant", got, rr_exp[k]);
      if (k > 0) chk("rr_spacing", 2 + n, 4);
      step(); step();
      chk("rr_rsp", RSP_VALID, got);
    end
    REQ_VALID = 2'b00;
    step(); step();

    // Timeout after WAIT_LIMIT stalled ACCESS cycles.
    PREADY = 1'b0;
    set_req(0, 1'b0, 32'h10, 32'h0);
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    step();
    for (int k = 1; k < WAIT_LIMIT; k++) step();
    chk("d4_last_access_penable", PENABLE, 1'b1);
    step();
    chk("d4_rsp_valid", RSP_VALID, 2'b01);
    chk("d4_rsp_err", RSP_ERR, 1'b1);
    chk("d4_rsp_timeout", RSP_TIMEOUT, 1'b1);
    chk("d4_rsp_rdata", RSP_RDATA, 32'h0);
    chk("d4_psel_low", PSELx, 1'b0);
    step(); step();

    // PREADY arriving on the final allowed ACCESS cycle completes normally.
    set_req(0, 1'b0, 32'h14, 32'h0);
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    step();
    for (int k = 1; k < WAIT_LIMIT; k++) step();
    PREADY = 1'b1;
    PRDATA = 32'hCAFEF00D;
    step();
    chk("d4b_rsp_timeout", RSP_TIMEOUT, 1'b0);
    chk("d4b_rsp_err", RSP_ERR, 1'b0);
    chk("d4b_rsp_rdata", RSP_RDATA, 32'hCAFEF00D);
    step(); step();

    // Slave error on a write to address 0; result holds afterwards.
    PSLVERR = 1'b1;
    set_req(1, 1'b1, 32'h0, 32'h55);
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    step(); step();
    chk("d5_rsp_valid", RSP_VALID, 2'b10);
    chk("d5_rsp_err", RSP_ERR, 1'b1);
    chk("d5_rsp_timeout", RSP_TIMEOUT, 1'b0);
    PSLVERR = 1'b0;
    step();
    chk("d5_err_hold", RSP_ERR, 1'b1);
    step();

    // Reset pulsed in the middle of an ACCESS cycle.
    PREADY = 1'b0;
    set_req(1, 1'b0, 32'h30, 32'h0);
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    step();
    #2 PRESETn = 1'b0;
    #1;
    chk("d6_async_psel", PSELx, 1'b0);
    chk("d6_async_penable", PENABLE, 1'b0);
    chk("d6_async_busy", BUSY, 1'b0);
    set_req(0, 1'b0, 32'h40, 32'h0);
    set_req(1, 1'b0, 32'h44, 32'h0);
    PREADY = 1'b1;
    step();
    chk("d6_rsp_in_reset", RSP_VALID, 2'b00);
    step();
    PRESETn = 1'b1;
    wait_acc(got, n);
    REQ_VALID = 2'b00;
    chk("d6_first_grant", got, 2'b01);
    step(); step();
    chk("d6_rsp_owner", RSP_VALID, 2'b01);
    step(); step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) begin
        #2 PRESETn = 1'b0;
        step(); step();
        PRESETn = 1'b1;
      end
      if (c % 200 == 0) mode = $urandom_range(0, 3);
      for (int i = 0; i < 2; i++) begin
        if (REQ_ACCEPT[i]) begin
          if ($urandom_range(0, 1) == 0) REQ_VALID[i] = 1'b0;
          else set_req(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom);
        end else if (!REQ_VALID[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          REQ_VALID[i] = 1'b0;
        end
        if (BUSY && $urandom_range(0, 2) == 0) begin
          REQ_ADDR[i*32 +: 32] = $urandom;
          REQ_WDATA[i*32 +: 32] = $urandom;
          REQ_WRITE[i] = 1'($urandom_range(0, 1));
        end
      end
      PREADY = (mode == 0) ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 2) == 0);
      PRDATA = $urandom;
      PSLVERR = ($urandom_range(0, 3) == 0);
    end

    REQ_VALID = 2'b00;
    PREADY = 1'b1;
    repeat (30) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
